dmem_resp: RTL

Data-memory responder: the memory end of the core's load/store path. Accepts one request at a time (word address, 4-bit byte-lane write enables, write data) through a valid/ready handshake, inserts a fixed number of wait states, commits byte-lane writes into a word array and returns the word at that address with a one-cycle response pulse. Sits between the core's load/store byte-lane controller and the data memory storage. It also flags out-of-range addresses and byte-lane patterns that do not correspond to an aligned access.

---
 rtl/dmem_resp.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the core's load/store path.
// Takes one request at a time, waits WAIT cycles, commits any byte-lane
// write into the word array and returns the resulting word with a
// one-cycle rsp_valid pulse. Out-of-range addresses and byte-lane patterns
// that do not form an aligned byte, half or word access are rejected with
// rsp_err and leave the array untouched.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high in IDLE and RESP, so a request held during the response
// cycle is taken with no idle gap. The requester keeps req_valid and the
// payload stable until the transfer. Responses cannot be stalled: rsp_valid
// is high for exactly one cycle, and drdata/rsp_err hold until the next access.
module dmem_resp #(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] daddr,
    input  logic [3:0]  we_dmem,
    input  logic [31:0] dwdata,
    output logic        rsp_valid,
    output logic [31:0] drdata,
    output logic        rsp_err,
    output logic [1:0]  state_dbg
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [29:0]  waddr_q, waddr_d;
    logic [3:0]   we_q, we_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [31:0]  drdata_q, drdata_d;
    logic         err_q, err_d;

    // Word storage; deliberately not reset.
    logic [31:0]  mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             lanes_ok;
    logic             access_ok;
    logic [31:0]      rd_word;
    logic [31:0]      merged_word;
    logic             do_access;
    logic             do_write;

    // Byte offset bits never select anything; words are always aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^daddr[1:0];

    assign idx       = waddr_q[IDX_W-1:0];
    assign in_range  = ~|waddr_q[29:IDX_W];
    assign rd_word   = mem[idx];
    assign access_ok = in_range && lanes_ok;
    assign do_write  = do_access && access_ok && (we_q != 4'b0000);

    assign req_ready = (state_q != BUSY);
    assign rsp_valid = (state_q == RESP);
    assign drdata    = drdata_q;
    assign rsp_err   = err_q;
    assign state_dbg = state_q;

    // Only aligned byte, half and word lane patterns (or a read) are legal.
    always_comb begin
        lanes_ok = 1'b0;
        case (we_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: lanes_ok = 1'b1;
            default:                   lanes_ok = 1'b0;
        endcase
    end

    // Overlay the enabled write lanes on the stored word.
    always_comb begin
        merged_word = rd_word;
        for (int k = 0; k < 4; k++) begin
            if (we_q[k]) begin
                merged_word[8*k +: 8] = wdata_q[8*k +: 8];
            end
        end
    end

    // Next-state and datapath control for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        drdata_d  = drdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (req_valid) begin
                    waddr_d = daddr[31:2];
                    we_d    = we_dmem;
                    wdata_d = dwdata;
                    cnt_d   = WAIT_CNT;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = RESP;
                    drdata_d  = access_ok ? merged_word : 32'd0;
                    err_d     = ~access_ok;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers; reset abandons any pending access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            waddr_q  <= 30'd0;
            we_q     <= 4'd0;
            wdata_q  <= 32'd0;
            drdata_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
        end
    end

    // Array commit on the access edge of a legal write.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= merged_word;
        end
    end

endmodule
